router_in_deser: RTL and testbench
==================================

Name: router_in_deser

Overview:
- RTL input-port deserializer for the 16x16 router: the receiving end of the serial frame protocol that the bench Driver produces on din/frame_n/valid_n.
- Recovers the 4-bit destination address and LSB-first payload bytes, then buffers them in a small FIFO.
- Presents a valid/ready byte stream, tagged with sop/eop/addr, to the router switch fabric.
- One instance per input port.

Parameters:
- ADDR_W, 4, destination address width (bits shifted LSB first).
- PAD_MIN, 5, minimum valid_n-high pad cycles between address and first data bit.
- FIFO_DEPTH, 16, byte entries in output FIFO (power of 2, >=4).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- din  in  1  serial data/address bit.
- frame_n  in  1  active-low frame; deasserts with last payload bit.
- valid_n  in  1  active-low data-bit qualifier.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  8  payload byte.
- out_sop  out  1  first byte of packet.
- out_eop  out  1  last byte of packet.
- out_addr  out  ADDR_W  destination port of packet.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- err_frame  out  1  one-cycle pulse: malformed/aborted frame.
- err_ovf  out  1  one-cycle pulse: byte dropped, FIFO full.

Behaviour:
- Reset: state=IDLE, counters 0, FIFO flushed. out_valid=0, out_data/out_addr=0, out_sop/out_eop=0, fifo_level=0, err_*=0. Reset mid-packet discards the partial packet; no eop emitted.
- States: IDLE, ADDR, PAD, DATA.
- IDLE:
  - frame_n=0 and valid_n=1: addr[0]<=din, bit_cnt=1, go ADDR.
  - frame_n=0 and valid_n=0: err_frame pulse, stay IDLE.
- ADDR:
  - Each cycle addr[bit_cnt]<=din.
  - After bit ADDR_W-1, go PAD with pad_cnt=0.
  - valid_n=0 or frame_n=1: err_frame, go IDLE.
- PAD:
  - valid_n=1: pad_cnt increments (saturating).
  - valid_n=0 with pad_cnt<PAD_MIN: err_frame, go IDLE.
  - valid_n=0 with pad_cnt>=PAD_MIN: shreg[0]<=din, bit_cnt=1, first=1, go DATA.
  - frame_n=1: err_frame, go IDLE (zero-length packet illegal).
- DATA:
  - valid_n=0: shreg[bit_cnt]<=din, bit_cnt++.
  - On bit_cnt=7, push {sop=first, eop=frame_n, addr, byte}; clear first; bit_cnt=0.
  - frame_n=1 on a push cycle: go IDLE.
  - valid_n=1 with frame_n=0: pause; no state change.
  - frame_n=1 on a non-push cycle (mid-byte, or while valid_n=1): err_frame, discard partial byte, go IDLE. Bytes already pushed remain without eop; the consumer treats err_frame as an abort.
- FIFO:
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and err_ovf pulses; the deserializer continues (the serial side cannot stall).
  - Pop when out_valid & out_ready.
  - Simultaneous push+pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_* reflect the FIFO head combinationally from registered storage.
- Latency: the byte whose bit 7 is sampled at edge T is visible on out_valid at T+1 when the FIFO was empty.
- Back-to-back: frame_n=0 in the cycle after an eop push starts a new address phase from IDLE.
- err_frame and err_ovf may pulse in the same cycle.

Decomposition:
- router_rtl_pkg:
  - typedef enum deser_state_e {IDLE, ADDR, PAD, DATA}
  - typedef struct packed router_byte_t {sop, eop, addr[3:0], data[7:0]}
  - localparams for address width and byte width
- Sub-module router_byte_fifo: synchronous FIFO of router_byte_t, parameter DEPTH, with push/pop/full/empty/level. The deserializer FSM stays in router_in_deser.

Test Plan:
- Single packet: addr=4'hA, 5 pad cycles, payload {8'h3C, 8'hA5}, out_ready=1 -> two bytes 3C (sop=1, addr=A), A5 (eop=1, addr=A); first out_valid one cycle after bit 7 of byte 0.
- Back-to-back: addr 3 with 1 byte 8'h01, then immediately addr 15 with 3 bytes -> 4 FIFO entries in order, correct sop/eop/addr; no err_frame.
- Backpressure/overflow: out_ready=0, 18-byte packet, FIFO_DEPTH=16 -> fifo_level=16, err_ovf pulses twice, bytes 17-18 lost; releasing out_ready drains 16 bytes.
- Framing errors: frame_n rises at bit 5 of byte 2 -> err_frame, bytes 0-1 delivered without eop; valid_n low after 3 pad cycles -> err_frame, nothing pushed.
- valid_n pauses: 3 idle cycles inserted mid-byte during payload 8'h96 -> byte 96 delivered intact.
- Reset mid-DATA after 1 byte pushed -> FIFO empty, out_valid=0; next clean packet received correctly.

Source files
------------

// File: rtl/router_rtl_pkg.sv
// rtl/router_rtl_pkg.sv - shared types for the router input deserializer
package router_rtl_pkg;

    localparam int RT_ADDR_W = 4;
    localparam int RT_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        PAD,
        DATA
    } deser_state_e;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [RT_ADDR_W-1:0] addr;
        logic [RT_BYTE_W-1:0] data;
    } router_byte_t;

endpackage

// File: rtl/router_byte_fifo.sv
// rtl/router_byte_fifo.sv - synchronous FIFO of tagged router bytes
module router_byte_fifo
    import router_rtl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  router_byte_t           i_data,
    input  logic                   i_pop,
    output router_byte_t           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_push_ok,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    router_byte_t     r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_level;
    logic             w_pop;
    logic             w_push;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign w_pop     = i_pop & ~o_empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push    = i_push & (~o_full | w_pop);
    assign o_push_ok = w_push;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PW+1)'(1);
                2'b01:   r_level <= r_level - (PW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/router_in_deser.sv
// rtl/router_in_deser.sv - serial frame deserializer feeding a tagged byte FIFO
module router_in_deser
    import router_rtl_pkg::*;
#(
    parameter int ADDR_W     = RT_ADDR_W,
    parameter int PAD_MIN    = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        din,
    input  logic                        frame_n,
    input  logic                        valid_n,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_frame,
    output logic                        err_ovf
);

    localparam int PAD_W = $clog2(PAD_MIN + 1);
    localparam logic [PAD_W-1:0] PAD_MIN_C = PAD_W'(PAD_MIN);
    localparam logic [2:0]       ADDR_LAST = 3'(ADDR_W - 1);

    deser_state_e       r_state;
    logic [2:0]         r_bit_cnt;
    logic [PAD_W-1:0]   r_pad_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [6:0]         r_shreg;
    logic               r_first;
    logic               r_push;
    router_byte_t       r_push_byte;
    logic               r_err_frame;
    logic               r_err_ovf;

    router_byte_t       w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_push_ok;
    logic               w_pop;

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign out_data  = out_valid ? w_head.data : '0;
    assign out_sop   = out_valid & w_head.sop;
    assign out_eop   = out_valid & w_head.eop;
    assign out_addr  = out_valid ? w_head.addr : '0;
    assign err_frame = r_err_frame;
    assign err_ovf   = r_err_ovf;

    // Address and payload are LSB first, so both shift in from the top.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_pad_cnt   <= '0;
            r_addr      <= '0;
            r_shreg     <= '0;
            r_first     <= 1'b0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovf   <= r_push & ~w_push_ok;
            case (r_state)
                IDLE: begin
                    if (!frame_n) begin
                        if (valid_n) begin
                            r_addr    <= {din, r_addr[ADDR_W-1:1]};
                            r_bit_cnt <= 3'd1;
                            r_state   <= ADDR;
                        end else begin
                            r_err_frame <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (!valid_n || frame_n) begin
                        r_err_frame <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_addr <= {din, r_addr[ADDR_W-1:1]};
                        if (r_bit_cnt == ADDR_LAST) begin
                            r_pad_cnt <= '0;
                            r_state   <= PAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PAD: begin
                    if (frame_n) begin
                        r_err_frame <= 1'b1;
                        r_state     <= IDLE;
                    end else if (valid_n) begin
                        if (r_pad_cnt < PAD_MIN_C) begin
                            r_pad_cnt <= r_pad_cnt + PAD_W'(1);
                        end
                    end else if (r_pad_cnt < PAD_MIN_C) begin
                        r_err_frame <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_shreg   <= {din, r_shreg[6:1]};
                        r_bit_cnt <= 3'd1;
                        r_first   <= 1'b1;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (!valid_n && r_bit_cnt == 3'd7) begin
                        r_push      <= 1'b1;
                        r_push_byte <= {r_first, frame_n, r_addr, din, r_shreg};
                        r_first     <= 1'b0;
                        r_bit_cnt   <= 3'd0;
                        if (frame_n) begin
                            r_state <= IDLE;
                        end
                    end else if (frame_n) begin
                        r_err_frame <= 1'b1;
                        r_state     <= IDLE;
                    end else if (!valid_n) begin
                        r_shreg   <= {din, r_shreg[6:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    router_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_push    (r_push),
        .i_data    (r_push_byte),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_push_ok (w_push_ok),
        .o_level   (fifo_level)
    );

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_router_in_deser.sv
// tb/tb_router_in_deser.sv - directed self-checking bench for router_in_deser
module tb_router_in_deser;

    logic       clock = 1'b0;
    logic       reset;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic [3:0] out_addr;
    logic [4:0] fifo_level;
    logic       err_frame;
    logic       err_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_errf = 0;
    int n_ovf  = 0;

    logic [13:0] rx_q[$];
    int          rx_cyc[$];
    logic [7:0]  pay [0:31];

    router_in_deser dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_addr   (out_addr),
        .fifo_level (fifo_level),
        .err_frame  (err_frame),
        .err_ovf    (err_ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                rx_q.push_back({out_sop, out_eop, out_addr, out_data});
                rx_cyc.push_back(cyc);
            end
            if (err_frame) n_errf++;
            if (err_ovf) n_ovf++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ent(input logic sop, input logic eop,
                                        input logic [3:0] a, input logic [7:0] d);
        return {sop, eop, a, d};
    endfunction

    task automatic chk_rx(input string tag, input int idx, input logic [13:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? {18'd0, rx_q[idx]} : 32'hDEAD;
        chk(tag, got, {18'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic f_n, input logic v_n, input logic d);
        frame_n = f_n;
        valid_n = v_n;
        din     = d;
        tick(1);
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_addr(input logic [3:0] a, input int npad);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, a[i]);
        repeat (npad) send_bit(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last,
                             input int pause_bit, input int npause);
        for (int i = 0; i < 8; i++) begin
            if (i == pause_bit) repeat (npause) send_bit(1'b0, 1'b1, 1'b0);
            send_bit((last && i == 7) ? 1'b1 : 1'b0, 1'b0, b[i]);
        end
    endtask

    task automatic send_packet(input logic [3:0] a, input int npad, input int nbytes);
        send_addr(a, npad);
        for (int k = 0; k < nbytes; k++) send_byte(pay[k], (k == nbytes - 1), 8, 0);
    endtask

    int base;
    int errf0;
    int ovf0;
    int t7;

    initial begin
        reset     = 1'b1;
        din       = 1'b0;
        frame_n   = 1'b1;
        valid_n   = 1'b1;
        out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_tags", {26'd0, out_sop, out_eop, out_addr}, 32'd0);
        chk("rst_err", {30'd0, err_frame, err_ovf}, 32'd0);

        // single packet with latency check
        out_ready = 1'b1;
        base = rx_q.size();
        errf0 = n_errf;
        send_addr(4'hA, 5);
        send_byte(8'h3C, 1'b0, 8, 0);
        t7 = cyc;
        send_byte(8'hA5, 1'b1, 8, 0);
        idle(4);
        chk("p1_count", rx_q.size() - base, 32'd2);
        chk_rx("p1_b0", base, ent(1'b1, 1'b0, 4'hA, 8'h3C));
        chk_rx("p1_b1", base + 1, ent(1'b0, 1'b1, 4'hA, 8'hA5));
        chk("p1_latency", (rx_cyc.size() > base) ? rx_cyc[base] - t7 : -1, 32'd1);
        chk("p1_errf", n_errf - errf0, 32'd0);

        // back-to-back packets
        base = rx_q.size();
        errf0 = n_errf;
        pay[0] = 8'h01;
        send_packet(4'h3, 5, 1);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_packet(4'hF, 5, 3);
        idle(4);
        chk("b2b_count", rx_q.size() - base, 32'd4);
        chk_rx("b2b_0", base,     ent(1'b1, 1'b1, 4'h3, 8'h01));
        chk_rx("b2b_1", base + 1, ent(1'b1, 1'b0, 4'hF, 8'h11));
        chk_rx("b2b_2", base + 2, ent(1'b0, 1'b0, 4'hF, 8'h22));
        chk_rx("b2b_3", base + 3, ent(1'b0, 1'b1, 4'hF, 8'h33));
        chk("b2b_errf", n_errf - errf0, 32'd0);

        // overflow under backpressure
        out_ready = 1'b0;
        ovf0 = n_ovf;
        errf0 = n_errf;
        for (int k = 0; k < 18; k++) pay[k] = 8'h40 + 8'(k);
        send_packet(4'h7, 5, 18);
        idle(3);
        chk("ovf_level", {27'd0, fifo_level}, 32'd16);
        chk("ovf_pulses", n_ovf - ovf0, 32'd2);
        chk("ovf_head", {18'd0, out_sop, out_eop, out_addr, out_data},
            {18'd0, ent(1'b1, 1'b0, 4'h7, 8'h40)});
        base = rx_q.size();
        out_ready = 1'b1;
        idle(20);
        chk("ovf_drain", rx_q.size() - base, 32'd16);
        chk_rx("ovf_first", base, ent(1'b1, 1'b0, 4'h7, 8'h40));
        chk_rx("ovf_last", base + 15, ent(1'b0, 1'b0, 4'h7, 8'h4F));
        chk("ovf_level0", {27'd0, fifo_level}, 32'd0);
        chk("ovf_errf", n_errf - errf0, 32'd0);

        // frame_n rises at bit 5 of third byte
        base = rx_q.size();
        errf0 = n_errf;
        send_addr(4'h6, 5);
        send_byte(8'h11, 1'b0, 8, 0);
        send_byte(8'h22, 1'b0, 8, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        idle(4);
        chk("abort_errf", n_errf - errf0, 32'd1);
        chk("abort_count", rx_q.size() - base, 32'd2);
        chk_rx("abort_b0", base,     ent(1'b1, 1'b0, 4'h6, 8'h11));
        chk_rx("abort_b1", base + 1, ent(1'b0, 1'b0, 4'h6, 8'h22));

        // short pad
        base = rx_q.size();
        errf0 = n_errf;
        send_addr(4'h2, 3);
        send_bit(1'b0, 1'b0, 1'b1);
        idle(4);
        chk("pad_errf", n_errf - errf0, 32'd1);
        chk("pad_count", rx_q.size() - base, 32'd0);

        // valid_n pause mid-byte
        base = rx_q.size();
        errf0 = n_errf;
        send_addr(4'h9, 5);
        send_byte(8'h96, 1'b1, 4, 3);
        idle(4);
        chk("pause_count", rx_q.size() - base, 32'd1);
        chk_rx("pause_b0", base, ent(1'b1, 1'b1, 4'h9, 8'h96));
        chk("pause_errf", n_errf - errf0, 32'd0);

        // reset mid-DATA
        out_ready = 1'b0;
        send_addr(4'h5, 5);
        send_byte(8'h77, 1'b0, 8, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b1);
        chk("mid_level", {27'd0, fifo_level}, 32'd1);
        frame_n = 1'b1;
        valid_n = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_level", {27'd0, fifo_level}, 32'd0);
        out_ready = 1'b1;
        base = rx_q.size();
        errf0 = n_errf;
        pay[0] = 8'h5A;
        send_packet(4'hC, 5, 1);
        idle(4);
        chk("rst2_count", rx_q.size() - base, 32'd1);
        chk_rx("rst2_b0", base, ent(1'b1, 1'b1, 4'hC, 8'h5A));
        chk("rst2_errf", n_errf - errf0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
